alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the processor's combinational ALU. It registers each operation and presents the result through valid/ready handshakes on both input and output, so the execute stage can stall and back-pressure it. It keeps the existing 4-bit operation encoding and adds an optional iterative multiplier with multi-cycle latency. It sits between the decode/operand-read stage and the writeback stage.

## Interface
- WIDTH, 32: operand and result width. Must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  4  operation code; encoding listed under Operation.
- a  input  WIDTH  operand 1.
- b  input  WIDTH  operand 2.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0; registered together with result.
- busy  output  1  a multiply is iterating.

## Operation
- Op codes:
  - 0 add, 1 sub, 2 xor, 3 or, 4 and.
  - 5 sll, 6 srl, 7 sra: shift amount is b[SHW-1:0].
  - 8 slt (signed), 9 sltu: result is 1 or 0, zero-extended.
  - 10 mul: low WIDTH bits of the product.
  - 11 mulhu: high WIDTH bits of the unsigned product.
  - 12–15: result 0.
- Add, sub and mul wrap modulo 2^WIDTH. No carry or overflow output.
- State machine has three states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On accept (in_valid && in_ready):
    - op 10 or 11 goes to MUL and loads multiplicand, multiplier, 2·WIDTH accumulator and a bit counter of 0.
    - Any other op computes the result, registers it into result/zero and goes to DONE.
  - MUL: one shift-add step per cycle, LSB of multiplier first. After WIDTH steps, load result (low or high half per the latched op) and go to DONE. busy=1 only in MUL.
  - DONE: out_valid=1; result and zero hold stable until the handshake completes.
    - out_ready=1: the result is consumed and in_ready=1 in the same cycle (pass-through). A simultaneous accept starts the next op exactly as from IDLE. With no new op, return to IDLE.
    - out_ready=0: in_ready=0; stay in DONE.
- in_ready is combinational from state and out_ready only. No combinational path from a, b or op to any output.
- Op code and operands are latched at accept. Later changes on inputs have no effect.

## Timing
- Reset value of every output register: result=0, zero=1, out_valid=0, busy=0, state=IDLE.
- Reset asserted mid-multiply or in DONE discards the operation; no output handshake follows.
- Simple op accepted at edge N: out_valid=1 after edge N; latency 1 cycle.
- Throughput: one simple op per cycle while out_ready stays 1.
- Multiply accepted at edge N: busy=1 from N+1 through N+WIDTH; out_valid=1 after edge N+WIDTH; latency WIDTH cycles.
- Input is not accepted during MUL (in_ready=0).

## Configuration
- ALU_SEQ_MUL_EN defined: ops 10 and 11 run the multiplier as described above.
- ALU_SEQ_MUL_EN undefined:
  - The multiplier, MUL state and counter are not built; busy is tied to 0.
  - Ops 10 and 11 behave like ops 12–15: 1-cycle latency, result 0.

## Test plan
- Reset, then idle: result=0, zero=1, out_valid=0, in_ready=1.
- Back-to-back ops with out_ready=1, WIDTH=32: add 5+7 → 12; sub 4−4 → 0 with zero=1; sra 0x80000001 by 1 → 0xC0000000; slt −1,1 → 1; sltu −1,1 → 0. One result per cycle, in order.
- Back-pressure: hold out_ready=0 for 3 cycles after an add. result stays stable, in_ready=0, and no second op is accepted until out_ready rises.
- With ALU_SEQ_MUL_EN:
  - mul 0xFFFFFFFF×2 → 0xFFFFFFFE; mulhu of the same operands → 1.
  - out_valid rises exactly 32 cycles after accept; busy is high for those 32 cycles.
- Reset pulsed on cycle 10 of a multiply: no out_valid follows, and a new add is accepted on the next cycle.
- Without ALU_SEQ_MUL_EN: op 10 with 3×3 → result 0 after 1 cycle; busy never asserts.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with optional iterative shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the multiplier for ops 10 (mul) and 11 (mulhu).
module alu_seq #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t           r_state, w_state_next, w_start_state;
  logic             r_zero;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_alu;
  logic [SHW-1:0]   w_shamt;
  logic             w_accept;
  logic             w_load_alu;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign w_shamt   = b[SHW-1:0];

  // Single-cycle operations, evaluated straight from the inputs at accept.
  always_comb begin
    w_alu = '0;
    case (op)
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_XOR:  w_alu = a ^ b;
      OP_OR:   w_alu = a | b;
      OP_AND:  w_alu = a & b;
      OP_SLL:  w_alu = a << w_shamt;
      OP_SRL:  w_alu = a >> w_shamt;
      OP_SRA:  w_alu = WIDTH'($signed(a) >>> w_shamt);
      OP_SLT:  w_alu = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: w_alu = WIDTH'(a < b);
      default: w_alu = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_next;
  logic [WIDTH-1:0]   r_mplier, w_mul_res;
  logic [SHW-1:0]     r_cnt;
  logic               r_hi;
  logic               w_is_mul, w_last;

  assign w_is_mul      = (op == OP_MUL) || (op == OP_MULHU);
  assign w_load_alu    = w_accept && !w_is_mul;
  assign w_start_state = w_is_mul ? S_MUL : S_DONE;
  assign busy          = (r_state == S_MUL);
  assign w_last        = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH - 1));
  assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_res     = r_hi ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];

  // One shift-add step per cycle, multiplier LSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= (op == OP_MULHU);
    end else if (r_state == S_MUL) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_next;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_load_alu    = w_accept;
  assign w_start_state = S_DONE;
  assign busy          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_start_state;
`ifdef ALU_SEQ_MUL_EN
      S_MUL:  if (w_last) w_state_next = S_DONE;
`endif
      S_DONE: if (out_ready) w_state_next = w_accept ? w_start_state : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result holds in DONE until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_load_alu) begin
      r_result <= w_alu;
      r_zero   <= (w_alu == '0);
    end
`ifdef ALU_SEQ_MUL_EN
    else if (w_last) begin
      r_result <= w_mul_res;
      r_zero   <= (w_mul_res == '0);
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); multiply tests follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_seen = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy === 1'b1) busy_seen++;

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
    n_checks++; if (zero !== 1'b1) $display("FAIL reset_zero got %b want 1", zero); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    localparam int N = 13;
    logic [3:0]  t_op  [N];
    logic [31:0] t_a   [N];
    logic [31:0] t_b   [N];
    logic [31:0] t_exp [N];
    t_op[0]  = 4'd0;  t_a[0]  = 32'd5;         t_b[0]  = 32'd7;         t_exp[0]  = 32'd12;
    t_op[1]  = 4'd1;  t_a[1]  = 32'd4;         t_b[1]  = 32'd4;         t_exp[1]  = 32'd0;
    t_op[2]  = 4'd7;  t_a[2]  = 32'h80000001;  t_b[2]  = 32'd1;         t_exp[2]  = 32'hC0000000;
    t_op[3]  = 4'd8;  t_a[3]  = 32'hFFFFFFFF;  t_b[3]  = 32'd1;         t_exp[3]  = 32'd1;
    t_op[4]  = 4'd9;  t_a[4]  = 32'hFFFFFFFF;  t_b[4]  = 32'd1;         t_exp[4]  = 32'd0;
    t_op[5]  = 4'd0;  t_a[5]  = 32'hFFFFFFFF;  t_b[5]  = 32'd1;         t_exp[5]  = 32'd0;
    t_op[6]  = 4'd2;  t_a[6]  = 32'h0000F0F0;  t_b[6]  = 32'h0000FF00;  t_exp[6]  = 32'h00000FF0;
    t_op[7]  = 4'd5;  t_a[7]  = 32'd1;         t_b[7]  = 32'h0000003F;  t_exp[7]  = 32'h80000000;
    t_op[8]  = 4'd6;  t_a[8]  = 32'h80000000;  t_b[8]  = 32'd4;         t_exp[8]  = 32'h08000000;
    t_op[9]  = 4'd3;  t_a[9]  = 32'h000000F0;  t_b[9]  = 32'h00000F00;  t_exp[9]  = 32'h00000FF0;
    t_op[10] = 4'd4;  t_a[10] = 32'h0000F0F0;  t_b[10] = 32'h0000FF00;  t_exp[10] = 32'h0000F000;
    t_op[11] = 4'd13; t_a[11] = 32'h00000ABC;  t_b[11] = 32'h00000DEF;  t_exp[11] = 32'd0;
    t_op[12] = 4'd1;  t_a[12] = 32'd0;         t_b[12] = 32'd1;         t_exp[12] = 32'hFFFFFFFF;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); else n_pass++;
      in_valid = 1'b1; op = t_op[i]; a = t_a[i]; b = t_b[i];
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_out_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
      n_checks++; if (result !== t_exp[i]) $display("FAIL b2b_result[%0d] got %h want %h", i, result, t_exp[i]); else n_pass++;
      n_checks++; if (zero !== (t_exp[i] == 32'd0)) $display("FAIL b2b_zero[%0d] got %b want %b", i, zero, (t_exp[i] == 32'd0)); else n_pass++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    a = 32'd10; b = 32'd10;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
      n_checks++; if (result !== 32'd7) $display("FAIL bp_result[%0d] got %h want 7", i, result); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_pass_through got %b want 1", in_ready); else n_pass++;
    n_checks++; if (result !== 32'd7) $display("FAIL bp_hold_result got %h want 7", result); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (result !== 32'd20) $display("FAIL bp_next_result got %h want 20", result); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_next_valid got %b want 1", out_valid); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_done();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rdone_pre_valid got %b want 1", out_valid); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rdone_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (result !== 32'd0) $display("FAIL rdone_result got %h want 0", result); else n_pass++;
    n_checks++; if (zero !== 1'b1) $display("FAIL rdone_zero got %b want 1", zero); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic run_mul(input logic [3:0] t_op, input logic [31:0] t_a,
                         input logic [31:0] t_b, input logic [31:0] t_exp);
    int lat, busy_cnt, stall_bad;
    lat = 0; busy_cnt = 0; stall_bad = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 4'd0; a = 32'h12345678; b = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c - 1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (in_ready !== 1'b0) stall_bad++;
    end
    n_checks++; if (lat !== 32) $display("FAIL mul_latency op%0d got %0d want 32", t_op, lat); else n_pass++;
    n_checks++; if (busy_cnt !== 32) $display("FAIL mul_busy_cycles op%0d got %0d want 32", t_op, busy_cnt); else n_pass++;
    n_checks++; if (stall_bad !== 0) $display("FAIL mul_in_ready op%0d got %0d ready cycles want 0", t_op, stall_bad); else n_pass++;
    n_checks++; if (result !== t_exp) $display("FAIL mul_result op%0d got %h want %h", t_op, result, t_exp); else n_pass++;
    n_checks++; if (zero !== (t_exp == 32'd0)) $display("FAIL mul_zero op%0d got %b want %b", t_op, zero, (t_exp == 32'd0)); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mul_busy_done op%0d got %b want 0", t_op, busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mul_drain op%0d got %b want 0", t_op, out_valid); else n_pass++;
  endtask

  task automatic test_mul();
    run_mul(4'd10, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
    run_mul(4'd11, 32'hFFFFFFFF, 32'd2, 32'd1);
    run_mul(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_mul(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 4'd10; a = 32'd6; b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL rmul_busy got %b want 1", busy); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmul_busy_after got %b want 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmul_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rmul_in_ready got %b want 1", in_ready); else n_pass++;
    in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rmul_add_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (result !== 32'd3) $display("FAIL rmul_add_result got %h want 3", result); else n_pass++;
    @(negedge clk);
  endtask
`else
  task automatic test_no_mul();
    out_ready = 1'b1;
    for (int i = 10; i <= 11; i++) begin
      in_valid = 1'b1; op = 4'(i); a = 32'd3; b = 32'd3;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL nomul_valid op%0d got %b want 1", i, out_valid); else n_pass++;
      n_checks++; if (result !== 32'd0) $display("FAIL nomul_result op%0d got %h want 0", i, result); else n_pass++;
      n_checks++; if (zero !== 1'b1) $display("FAIL nomul_zero op%0d got %b want 1", i, zero); else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (busy_seen !== 0) $display("FAIL nomul_busy_seen got %0d want 0", busy_seen); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_reset_in_done();
`ifdef ALU_SEQ_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_no_mul();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
